// File: rtl/local_network_interface.sv
// Core-side network interface: packetising credit-based injection plus buffered, credit-returning ejection.
// Optional NI_STATS_EN adds header and RX-push statistics counters.
module local_network_interface #(
  parameter int FLIT_W     = 16,
  parameter int PKT_LEN    = 4,
  parameter int TX_CREDITS = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       tx_dest_i,
  input  logic [FLIT_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [FLIT_W-1:0] ni_flit_o,
  output logic              ni_valid_o,
  input  logic              ni_credit_i,
  input  logic [FLIT_W-1:0] ni_flit_i,
  input  logic              ni_valid_i,
  output logic              ni_credit_o,
  output logic [FLIT_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
`ifdef NI_STATS_EN
  output logic [15:0]       stat_tx_pkts_o,
  output logic [15:0]       stat_rx_flits_o,
`endif
  output logic              ni_err_o
);

  // state  | meaning
  // S_IDLE | waiting to issue a header flit
  // S_BODY | issuing PKT_LEN-1 body flits from the core

  localparam int CR_W  = $clog2(TX_CREDITS + 1);
  localparam int CNT_W = (PKT_LEN > 2) ? $clog2(PKT_LEN - 1) : 1;
  localparam int PTR_W = $clog2(RX_DEPTH);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  state_t            r_state;
  logic [CR_W-1:0]   r_credits;
  logic [CNT_W-1:0]  r_cnt;
  logic [FLIT_W-1:0] r_flit;
  logic              r_valid;
  logic              r_err;
  logic              r_credit_out;
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [FLIT_W-1:0] r_mem [RX_DEPTH];

  logic w_cr_nz, w_cr_full, w_hdr, w_body, w_send, w_cr_ovf;
  logic w_empty, w_full, w_pop, w_push, w_rx_drop;

  assign w_cr_nz   = (r_credits != '0);
  assign w_cr_full = (r_credits == CR_W'(TX_CREDITS));
  assign w_hdr     = (r_state == S_IDLE) && tx_valid_i && w_cr_nz;
  assign w_body    = (r_state == S_BODY) && tx_valid_i && w_cr_nz;
  assign w_send    = w_hdr || w_body;
  assign w_cr_ovf  = ni_credit_i && !w_send && w_cr_full;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop     = !w_empty && rx_ready_i;
  // A full FIFO can still take a flit when the head leaves in the same cycle.
  assign w_push    = ni_valid_i && (!w_full || w_pop);
  assign w_rx_drop = ni_valid_i && w_full && !w_pop;

  assign tx_ready_o  = (r_state == S_BODY) && w_cr_nz;
  assign ni_flit_o   = r_flit;
  assign ni_valid_o  = r_valid;
  assign ni_credit_o = r_credit_out;
  assign ni_err_o    = r_err;
  assign rx_data_o   = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign rx_valid_o  = !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_credits <= CR_W'(TX_CREDITS);
      r_cnt     <= '0;
      r_flit    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_send;
      if (w_send) r_flit <= w_hdr ? FLIT_W'(tx_dest_i) : tx_data_i;

      if (w_send && !ni_credit_i)
        r_credits <= r_credits - CR_W'(1);
      else if (!w_send && ni_credit_i && !w_cr_full)
        r_credits <= r_credits + CR_W'(1);

      case (r_state)
        S_IDLE: if (w_hdr) begin
          r_cnt   <= '0;
          r_state <= S_BODY;
        end
        S_BODY: if (w_body) begin
          if (r_cnt == CNT_W'(PKT_LEN - 2)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_credit_out <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_credit_out <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_err <= r_err || w_cr_ovf || w_rx_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= ni_flit_i;
  end

`ifdef NI_STATS_EN
  logic [15:0] r_stat_tx_pkts;
  logic [15:0] r_stat_rx_flits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_tx_pkts  <= '0;
      r_stat_rx_flits <= '0;
    end else begin
      if (w_hdr)  r_stat_tx_pkts  <= r_stat_tx_pkts + 16'd1;
      if (w_push) r_stat_rx_flits <= r_stat_rx_flits + 16'd1;
    end
  end

  assign stat_tx_pkts_o  = r_stat_tx_pkts;
  assign stat_rx_flits_o = r_stat_rx_flits;
`endif

endmodule

// File: tb/tb_local_network_interface.sv
// Directed bench for local_network_interface: packetising, credit flow, RX FIFO limits and mid-packet reset.
module tb_local_network_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tx_dest_i;
  logic [15:0] tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [15:0] ni_flit_o;
  logic        ni_valid_o;
  logic        ni_credit_i;
  logic [15:0] ni_flit_i;
  logic        ni_valid_i;
  logic        ni_credit_o;
  logic [15:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        ni_err_o;

  int errors = 0;
  int checks = 0;

  local_network_interface dut (
    .clk        (clk),
    .reset      (reset),
    .tx_dest_i  (tx_dest_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .ni_flit_o  (ni_flit_o),
    .ni_valid_o (ni_valid_o),
    .ni_credit_i(ni_credit_i),
    .ni_flit_i  (ni_flit_i),
    .ni_valid_i (ni_valid_i),
    .ni_credit_o(ni_credit_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .ni_err_o   (ni_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    tx_valid_i  = 1'b0;
    ni_credit_i = 1'b0;
    ni_valid_i  = 1'b0;
    rx_ready_i  = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    tx_dest_i   = 16'h0102;
    tx_data_i   = 16'h00AA;
    tx_valid_i  = 1'b1;
    ni_credit_i = 1'b0;
    ni_flit_i   = 16'h0;
    ni_valid_i  = 1'b0;
    rx_ready_i  = 1'b0;
    tick();
    tick();

    chk("rst_valid",    ni_valid_o, 0);
    chk("rst_flit",     ni_flit_o, 16'h0);
    chk("rst_credit_o", ni_credit_o, 0);
    chk("rst_err",      ni_err_o, 0);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_cr",       dut.r_credits, 8);

    // Test 1: one packet, header + A,B,C
    reset = 1'b0;
    tick();
    chk("t1_hdr_valid", ni_valid_o, 1);
    chk("t1_hdr_flit",  ni_flit_o, 16'h0102);
    chk("t1_ready",     tx_ready_o, 1);
    tick();
    chk("t1_a_valid", ni_valid_o, 1);
    chk("t1_a_flit",  ni_flit_o, 16'h00AA);
    tx_data_i = 16'h00BB;
    tick();
    chk("t1_b_valid", ni_valid_o, 1);
    chk("t1_b_flit",  ni_flit_o, 16'h00BB);
    tx_data_i = 16'h00CC;
    tick();
    chk("t1_c_valid", ni_valid_o, 1);
    chk("t1_c_flit",  ni_flit_o, 16'h00CC);
    chk("t1_cr",      dut.r_credits, 4);
    tx_valid_i = 1'b0;
    tick();
    chk("t1_idle_valid", ni_valid_o, 0);
    chk("t1_flit_hold",  ni_flit_o, 16'h00CC);

    // Test 2: run credits out, then one credit releases exactly one flit
    tx_dest_i  = 16'h0304;
    tx_valid_i = 1'b1;
    tick();
    chk("t2_hdr_flit", ni_flit_o, 16'h0304);
    tx_data_i = 16'h00D1;
    tick();
    chk("t2_d1", ni_flit_o, 16'h00D1);
    tx_data_i = 16'h00D2;
    tick();
    chk("t2_d2", ni_flit_o, 16'h00D2);
    tx_data_i = 16'h00D3;
    tick();
    chk("t2_d3",       ni_flit_o, 16'h00D3);
    chk("t2_d3_valid", ni_valid_o, 1);
    chk("t2_cr0",      dut.r_credits, 0);
    tick();
    chk("t2_stall_valid", ni_valid_o, 0);
    chk("t2_stall_ready", tx_ready_o, 0);
    tick();
    chk("t2_stall2_valid", ni_valid_o, 0);
    tx_dest_i   = 16'h0506;
    ni_credit_i = 1'b1;
    tick();
    ni_credit_i = 1'b0;
    chk("t2_cr1",       dut.r_credits, 1);
    chk("t2_cr_valid0", ni_valid_o, 0);
    tick();
    chk("t2_one_valid", ni_valid_o, 1);
    chk("t2_one_flit",  ni_flit_o, 16'h0506);
    chk("t2_one_ready", tx_ready_o, 0);
    tick();
    chk("t2_after_valid", ni_valid_o, 0);
    chk("t2_after_ready", tx_ready_o, 0);

    // Test 3: simultaneous send+credit, then credit overflow at full count
    tx_valid_i  = 1'b0;
    ni_credit_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_cr3_pre", dut.r_credits, 3);
    tx_valid_i = 1'b1;
    tx_data_i  = 16'h00E1;
    tick();
    chk("t3_cr3_same", dut.r_credits, 3);
    chk("t3_e1_valid", ni_valid_o, 1);
    chk("t3_e1_flit",  ni_flit_o, 16'h00E1);
    ni_credit_i = 1'b0;
    tx_data_i   = 16'h00E2;
    tick();
    tx_data_i = 16'h00E3;
    tick();
    chk("t3_e3_flit", ni_flit_o, 16'h00E3);
    chk("t3_cr1",     dut.r_credits, 1);
    tx_valid_i  = 1'b0;
    ni_credit_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    ni_credit_i = 1'b0;
    chk("t3_cr8",       dut.r_credits, 8);
    chk("t3_err_clean", ni_err_o, 0);
    ni_credit_i = 1'b1;
    tick();
    ni_credit_i = 1'b0;
    chk("t3_cr8_hold", dut.r_credits, 8);
    chk("t3_err_ovf",  ni_err_o, 1);

    // Test 4: fill RX FIFO, overflow drop, drain in order with credit pulses
    tick();
    do_reset();
    chk("t4_err_cleared", ni_err_o, 0);
    for (int i = 0; i < 8; i++) begin
      ni_valid_i = 1'b1;
      ni_flit_i  = 16'hF000 + 16'(i);
      tick();
    end
    ni_valid_i = 1'b0;
    chk("t4_rx_valid", rx_valid_o, 1);
    chk("t4_head",     rx_data_o, 16'hF000);
    chk("t4_err0",     ni_err_o, 0);
    chk("t4_credit0",  ni_credit_o, 0);
    ni_valid_i = 1'b1;
    ni_flit_i  = 16'hF0FF;
    tick();
    ni_valid_i = 1'b0;
    chk("t4_drop_err", ni_err_o, 1);
    chk("t4_drop_head", rx_data_o, 16'hF000);
    rx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_pop_data", rx_data_o, 16'hF000 + 16'(i));
      chk("t4_pop_valid", rx_valid_o, 1);
      tick();
      chk("t4_pop_credit", ni_credit_o, 1);
    end
    rx_ready_i = 1'b0;
    chk("t4_empty", rx_valid_o, 0);
    tick();
    chk("t4_credit_end", ni_credit_o, 0);

    // Test 5: full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ni_valid_i = 1'b1;
      ni_flit_i  = 16'h5100 + 16'(i);
      tick();
    end
    ni_valid_i = 1'b0;
    chk("t5_full_err0", ni_err_o, 0);
    ni_valid_i = 1'b1;
    ni_flit_i  = 16'h5108;
    rx_ready_i = 1'b1;
    chk("t5_head", rx_data_o, 16'h5100);
    tick();
    ni_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    chk("t5_err0",    ni_err_o, 0);
    chk("t5_credit1", ni_credit_o, 1);
    chk("t5_head2",   rx_data_o, 16'h5101);
    tick();
    chk("t5_credit_single", ni_credit_o, 0);
    rx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t5_drain", rx_data_o, 16'h5101 + 16'(i));
      tick();
    end
    rx_ready_i = 1'b0;
    chk("t5_empty", rx_valid_o, 0);

    // Test 6: reset mid-packet
    tick();
    do_reset();
    tx_dest_i  = 16'h0708;
    tx_data_i  = 16'h0011;
    tx_valid_i = 1'b1;
    tick();
    chk("t6_hdr", ni_flit_o, 16'h0708);
    tick();
    chk("t6_body",  ni_flit_o, 16'h0011);
    chk("t6_ready", tx_ready_o, 1);
    reset = 1'b1;
    #2;
    chk("t6_rst_valid", ni_valid_o, 0);
    chk("t6_rst_cr",    dut.r_credits, 8);
    chk("t6_rst_ready", tx_ready_o, 0);
    tx_dest_i = 16'h0908;
    tx_data_i = 16'h0022;
    reset = 1'b0;
    tick();
    chk("t6_new_valid", ni_valid_o, 1);
    chk("t6_new_hdr",   ni_flit_o, 16'h0908);
    chk("t6_new_cr",    dut.r_credits, 7);
    tx_valid_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
